// File: rtl/rails_stack_checker.sv
// rails_stack_checker
//   Decides whether a requested departure order of trains 1..N is achievable
//   through a single-ended LIFO siding. Trains arrive in ascending order.
//   Input is a count word N, then N departure train numbers. The block
//   replays the yard one action per cycle and reports a verdict pulse.
//
//   Optional feature macro: RAILS_SEQ_CHK_EN. When it is defined, the block
//   screens each departure word as it loads. Words that are 0, larger than N,
//   or repeated are flagged, and the replay is skipped.
//
// Ports
//   clk       : clock, rising edge
//   reset     : asynchronous, active-high
//   in_valid  : in_data qualifier
//   in_data   : count word, then departure train numbers
//   in_ready  : high in IDLE and LOAD (low while reset is asserted)
//   valid     : one-cycle verdict pulse
//   result    : 1 = order achievable (qualified by valid)
//   fail_pos  : 0-based index of first unsatisfiable departure, 0 on success
//   err       : malformed input flag (bad count, or screened sequence)
module rails_stack_checker #(
   parameter int MAX_N = 16,
   parameter int DW    = 5
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          in_valid,
   input  logic [DW-1:0] in_data,
   output logic          in_ready,
   output logic          valid,
   output logic          result,
   output logic [DW-1:0] fail_pos,
   output logic          err
);

   localparam int            AW     = (MAX_N > 1) ? $clog2(MAX_N) : 1;
   localparam logic [DW-1:0] C_MAXN = DW'(MAX_N);
   localparam logic [DW-1:0] C_MINN = DW'(3);
   localparam logic [DW-1:0] C_ONE  = DW'(1);
   localparam logic [DW:0]   C_ONEW = (DW+1)'(1);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CHECK, S_DONE} state_t;
   state_t r_state, w_state_n;

   logic [DW-1:0] r_seq   [MAX_N];
   logic [DW-1:0] r_stack [MAX_N];
   logic [DW:0]   r_sp, r_nxt, r_j;
   logic [DW-1:0] r_cnt, r_li;
   logic          r_result, r_err;
   logic [DW-1:0] r_fail_pos;

   logic          w_acc, w_cnt_ld, w_start, w_wr, w_push, w_pop, w_set;
   logic          w_res_n, w_err_n, w_match;
   logic [DW-1:0] w_pos_n, w_li_inc;
   logic [DW:0]   w_j_inc, w_cnt_ext;
   logic [AW-1:0] w_top_idx;

`ifdef RAILS_SEQ_CHK_EN
   logic [MAX_N-1:0] r_seen;
   logic             r_bad;
   logic [DW-1:0]    r_bad_pos;
   logic [AW-1:0]    w_seen_idx;
   logic             w_malf;
   // Train values 1..MAX_N map to bits 0..MAX_N-1; the AW-bit wrap keeps
   // train MAX_N on the top bit.
   assign w_seen_idx = in_data[AW-1:0] - AW'(1);
   assign w_malf     = (in_data == '0) || (in_data > r_cnt) || r_seen[w_seen_idx];
`endif

   assign in_ready  = ~reset && ((r_state == S_IDLE) || (r_state == S_LOAD));
   assign w_acc     = in_valid && in_ready;
   assign w_li_inc  = r_li + C_ONE;
   assign w_j_inc   = r_j + C_ONEW;
   assign w_cnt_ext = {1'b0, r_cnt};
   // sp-1 in AW bits; a full stack (sp == MAX_N) wraps to the last slot.
   assign w_top_idx = r_sp[AW-1:0] - AW'(1);
   assign w_match   = (r_sp != '0) && (r_stack[w_top_idx] == r_seq[r_j[AW-1:0]]);

   assign valid    = (r_state == S_DONE);
   assign result   = r_result;
   assign fail_pos = r_fail_pos;
   assign err      = r_err;

   always_comb begin
      w_state_n = r_state;
      w_cnt_ld  = 1'b0;
      w_start   = 1'b0;
      w_wr      = 1'b0;
      w_push    = 1'b0;
      w_pop     = 1'b0;
      w_set     = 1'b0;
      w_res_n   = 1'b0;
      w_err_n   = 1'b0;
      w_pos_n   = '0;
      case (r_state)
         S_IDLE: begin
            if (w_acc) begin
               w_cnt_ld = 1'b1;
               if ((in_data < C_MINN) || (in_data > C_MAXN)) begin
                  w_set     = 1'b1;
                  w_err_n   = 1'b1;
                  w_state_n = S_DONE;
               end else begin
                  w_start   = 1'b1;
                  w_state_n = S_LOAD;
               end
            end
         end
         S_LOAD: begin
            if (w_acc) begin
               w_wr = 1'b1;
               if (w_li_inc == r_cnt) w_state_n = S_CHECK;
            end
         end
         S_CHECK: begin
`ifdef RAILS_SEQ_CHK_EN
            if (r_bad) begin
               w_set     = 1'b1;
               w_err_n   = 1'b1;
               w_pos_n   = r_bad_pos;
               w_state_n = S_DONE;
            end else
`endif
            if (w_match) begin
               w_pop = 1'b1;
               if (w_j_inc == w_cnt_ext) begin
                  w_set     = 1'b1;
                  w_res_n   = 1'b1;
                  w_state_n = S_DONE;
               end
            end else if (r_nxt <= w_cnt_ext) begin
               w_push = 1'b1;
            end else begin
               w_set     = 1'b1;
               w_pos_n   = r_j[DW-1:0];
               w_state_n = S_DONE;
            end
         end
         S_DONE: w_state_n = S_IDLE;
         default: w_state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_sp       <= '0;
         r_nxt      <= '0;
         r_j        <= '0;
         r_cnt      <= '0;
         r_li       <= '0;
         r_result   <= 1'b0;
         r_err      <= 1'b0;
         r_fail_pos <= '0;
`ifdef RAILS_SEQ_CHK_EN
         r_seen     <= '0;
         r_bad      <= 1'b0;
         r_bad_pos  <= '0;
`endif
      end else begin
         r_state <= w_state_n;
         if (w_cnt_ld) r_cnt <= in_data;
         if (w_start) begin
            r_sp  <= '0;
            r_nxt <= C_ONEW;
            r_j   <= '0;
            r_li  <= '0;
`ifdef RAILS_SEQ_CHK_EN
            r_seen <= '0;
            r_bad  <= 1'b0;
`endif
         end
         if (w_wr) begin
            r_li <= w_li_inc;
`ifdef RAILS_SEQ_CHK_EN
            r_seen[w_seen_idx] <= 1'b1;
            // Sticky: only the first malformed word records its position.
            if (w_malf && !r_bad) begin
               r_bad     <= 1'b1;
               r_bad_pos <= r_li;
            end
`endif
         end
         if (w_push) begin
            r_sp  <= r_sp + C_ONEW;
            r_nxt <= r_nxt + C_ONEW;
         end
         if (w_pop) begin
            r_sp <= r_sp - C_ONEW;
            r_j  <= w_j_inc;
         end
         if (w_set) begin
            r_result   <= w_res_n;
            r_err      <= w_err_n;
            r_fail_pos <= w_pos_n;
         end
      end
   end

   // Sequence and siding storage carry no reset; pointers gate every read.
   always_ff @(posedge clk) begin
      if (w_wr)   r_seq[r_li[AW-1:0]]   <= in_data;
      if (w_push) r_stack[r_sp[AW-1:0]] <= r_nxt[DW-1:0];
   end

endmodule

// File: tb/tb_rails_stack_checker.sv
module tb_rails_stack_checker;
   localparam int MAX_N = 16;
   localparam int DW    = 5;

   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid;
   logic [DW-1:0] in_data;
   logic          in_ready;
   logic          valid;
   logic          result;
   logic [DW-1:0] fail_pos;
   logic          err;

   rails_stack_checker #(.MAX_N(MAX_N), .DW(DW)) dut (
      .clk      (clk),
      .reset    (reset),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .valid    (valid),
      .result   (result),
      .fail_pos (fail_pos),
      .err      (err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int res;
      int pos;
      int err;
      int lat;   // <= 0 means latency not checked
   } exp_t;

   exp_t exp_q[$];
   int   words[$];
   int   n_vec  = 0;
   int   n_fail = 0;
   int   hs_cyc = 0;

   task automatic chk(input string tag, input int obs, input int expv);
      n_vec++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic expect_v(input int res, input int pos, input int e, input int lat);
      exp_t x;
      x.res = res; x.pos = pos; x.err = e; x.lat = lat;
      exp_q.push_back(x);
   endtask

   // Called at posedge+1; returns at posedge+1 right after the handshake edge.
   task automatic send_word(input int w);
      bit rdy;
      bit ok;
      ok = 1'b0;
      in_valid = 1'b1;
      in_data  = DW'(w);
      for (int k = 0; k < 100; k++) begin
         rdy = in_ready;
         @(posedge clk); #1;
         if (rdy) begin ok = 1'b1; break; end
      end
      in_valid = 1'b0;
      if (!ok) chk("handshake_timeout", 0, 1);
      hs_cyc = cyc;
   endtask

   task automatic send_seq(input int cnt, input int gap);
      send_word(cnt);
      foreach (words[i]) begin
         repeat (gap) begin @(posedge clk); #1; end
         send_word(words[i]);
      end
   endtask

   task automatic wait_verdict(input bit check_pulse, input bit noise);
      exp_t e;
      bit   seen;
      int   lat;
      seen = 1'b0;
      if (exp_q.size() == 0) begin
         chk("scoreboard_empty", 0, 1);
         return;
      end
      e = exp_q.pop_front();
      for (int k = 0; k < 300; k++) begin
         if (valid) begin seen = 1'b1; break; end
         if (noise) begin
            in_valid = 1'b1;
            in_data  = DW'(9);
            chk("ready_low_busy", int'(in_ready), 0);
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      lat = cyc - hs_cyc + 1;
      chk("valid_seen", int'(seen), 1);
      if (seen) begin
         chk("result", int'(result), e.res);
         chk("fail_pos", int'(fail_pos), e.pos);
         chk("err", int'(err), e.err);
         if (e.lat > 0) chk("latency", lat, e.lat);
      end
      if (check_pulse) begin
         @(posedge clk); #1;
         chk("valid_one_cycle", int'(valid), 0);
         chk("result_hold", int'(result), e.res);
         chk("ready_idle", int'(in_ready), 1);
      end
   endtask

   initial begin
      int vcount;
      reset    = 1'b1;
      in_valid = 1'b0;
      in_data  = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", int'(in_ready), 0);
      chk("rst_valid", int'(valid), 0);
      chk("rst_result", int'(result), 0);
      chk("rst_fail_pos", int'(fail_pos), 0);
      chk("rst_err", int'(err), 0);
      reset = 1'b0;
      #1;
      chk("ready_after_rst", int'(in_ready), 1);
      @(posedge clk); #1;

      // Achievable order, exact success latency 2N+1
      words = '{4, 3, 2, 5, 1};
      expect_v(1, 0, 0, 11);
      send_seq(5, 0);
      wait_verdict(1'b1, 1'b0);

      // Fail at position 2, input noise during CHECK must be ignored
      words = '{2, 4, 1, 3, 6, 5};
      expect_v(0, 2, 0, 0);
      send_seq(6, 0);
      wait_verdict(1'b1, 1'b1);

      // Fail at position 1, then back-to-back count presented while valid is high
      words = '{3, 1, 2};
      expect_v(0, 1, 0, 0);
      send_seq(3, 0);
      wait_verdict(1'b0, 1'b0);
      words = '{1, 2, 3};
      expect_v(1, 0, 0, 7);
      send_seq(3, 0);
      wait_verdict(1'b1, 1'b0);

      // Bad counts
      words = {};
      expect_v(0, 0, 1, 1);
      send_seq(0, 0);
      wait_verdict(1'b1, 1'b0);
      expect_v(0, 0, 1, 1);
      send_seq(MAX_N + 1, 0);
      wait_verdict(1'b1, 1'b0);
      expect_v(0, 0, 1, 1);
      send_seq(2, 0);
      wait_verdict(1'b1, 1'b0);

      // Full-depth reverse order exercises a stack of MAX_N entries
      words = {};
      for (int i = MAX_N; i >= 1; i--) words.push_back(i);
      expect_v(1, 0, 0, 2 * MAX_N + 1);
      send_seq(MAX_N, 0);
      wait_verdict(1'b1, 1'b0);

      // Duplicate departure value
      words = '{1, 3, 3, 2};
`ifdef RAILS_SEQ_CHK_EN
      expect_v(0, 2, 1, 2);
`else
      expect_v(0, 2, 0, 0);
`endif
      send_seq(4, 0);
      wait_verdict(1'b1, 1'b0);

      // Reset mid-CHECK: no stale verdict, then a fresh sequence with gaps
      words = '{1, 2, 3, 4, 5};
      send_seq(5, 0);
      repeat (3) begin @(posedge clk); #1; end
      reset = 1'b1;
      #1;
      chk("midrst_ready", int'(in_ready), 0);
      chk("midrst_valid", int'(valid), 0);
      @(posedge clk); #1;
      reset = 1'b0;
      #1;
      chk("midrst_ready_idle", int'(in_ready), 1);
      vcount = 0;
      for (int k = 0; k < 20; k++) begin
         if (valid) vcount++;
         @(posedge clk); #1;
      end
      chk("no_stale_valid", vcount, 0);
      words = '{1, 2, 3};
      expect_v(1, 0, 0, 7);
      send_seq(3, 2);
      wait_verdict(1'b1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end
endmodule
